// File: rtl/jtpopeye_dma_ctrl.sv
// Sprite-DMA sequencer: on vertical blank, requests the Z80 bus, copies XFER_LEN
// steps from main RAM into object RAM, then releases the bus.
module jtpopeye_dma_ctrl #(
    parameter int XFER_LEN    = 1024,
    parameter int ACK_TIMEOUT = 255,
    parameter int FRAME_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       VB,
    input  logic [1:0] H,
    input  logic       dma_en,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic       dm_clr,
    output logic       dm_inc,
    output logic       dma_cs,
    output logic       dma_busy,
    output logic       dma_done,
    output logic       dma_tout
);
    localparam int CW = $clog2(XFER_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic            r_vbl;
    logic [3:0]      r_div;
    logic [7:0]      r_timer;
    logic [CW-1:0]   r_cnt;
    logic            r_busrq_n;
    logic            r_clr;
    logic            r_done;
    logic            r_tout;

    logic            w_vb_rise;
    logic            w_start;
    logic            w_inc;
    logic            w_last;

    assign w_vb_rise = VB & ~r_vbl;
    assign w_start   = w_vb_rise & (r_div == 4'd0) & dma_en;
    // The first XFER cen cycle carries dm_clr, so the counter step is held off there.
    assign w_inc     = cen & (r_state == S_XFER) & ~busak_n & (H == 2'b10) & ~r_clr;
    assign w_last    = (r_cnt == CW'(XFER_LEN - 1));

    assign busrq_n  = r_busrq_n;
    assign dm_clr   = r_clr & cen;
    assign dm_inc   = w_inc;
    assign dma_cs   = (r_state == S_XFER) & ~busak_n & ~H[1];
    assign dma_busy = (r_state != S_IDLE);
    assign dma_done = r_done & cen;
    assign dma_tout = r_tout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vbl     <= 1'b1;
            r_div     <= 4'd0;
            r_timer   <= 8'd0;
            r_cnt     <= '0;
            r_busrq_n <= 1'b1;
            r_clr     <= 1'b0;
            r_done    <= 1'b0;
            r_tout    <= 1'b0;
        end else if (cen) begin
            r_vbl  <= VB;
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            if (w_vb_rise)
                r_div <= (r_div == 4'(FRAME_DIV - 1)) ? 4'd0 : r_div + 4'd1;
            case (r_state)
                S_IDLE: begin
                    r_busrq_n <= 1'b1;
                    if (w_start) begin
                        r_state   <= S_REQ;
                        r_timer   <= 8'd0;
                        r_busrq_n <= 1'b0;
                        r_tout    <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!busak_n) begin
                        r_state <= S_XFER;
                        r_clr   <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_timer == 8'(ACK_TIMEOUT - 1)) begin
                        r_state   <= S_IDLE;
                        r_busrq_n <= 1'b1;
                        r_tout    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_XFER: begin
                    if (w_inc) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state   <= S_RELEASE;
                            r_busrq_n <= 1'b1;
                        end
                    end else if (busak_n) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!busak_n)
                        r_state <= S_XFER;
                end
                S_RELEASE: begin
                    if (busak_n) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busrq_n <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtpopeye_dma_ctrl.sv
// Self-checking bench for jtpopeye_dma_ctrl: table of DMA runs, randomized runs
// against a transaction-level model, plus reset and frame-divider sequences.
module tb_jtpopeye_dma_ctrl;
    localparam int XFER_LEN    = 1024;
    localparam int ACK_TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       VB = 1'b0;
    logic [1:0] H = 2'd0;
    logic       dma_en = 1'b1;
    logic       busak_n = 1'b1;
    logic       busak3_n = 1'b1;

    logic busrq_n, dm_clr, dm_inc, dma_cs, dma_busy, dma_done, dma_tout;
    logic busrq3_n, dm_clr3, dm_inc3, dma_cs3, dma_busy3, dma_done3, dma_tout3;

    jtpopeye_dma_ctrl dut (
        .clk(clk), .rst(rst), .cen(cen), .VB(VB), .H(H), .dma_en(dma_en),
        .busak_n(busak_n), .busrq_n(busrq_n), .dm_clr(dm_clr), .dm_inc(dm_inc),
        .dma_cs(dma_cs), .dma_busy(dma_busy), .dma_done(dma_done), .dma_tout(dma_tout)
    );

    jtpopeye_dma_ctrl #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .cen(cen), .VB(VB), .H(H), .dma_en(dma_en),
        .busak_n(busak3_n), .busrq_n(busrq3_n), .dm_clr(dm_clr3), .dm_inc(dm_inc3),
        .dma_cs(dma_cs3), .dma_busy(dma_busy3), .dma_done(dma_done3), .dma_tout(dma_tout3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lag;
        int cen_mode;
        int ack_on;
        int loss_at;
        int loss_len;
        int exp_strobes;
        int exp_clr;
        int exp_done;
        int exp_tout;
        int exp_rqlow;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // monitor totals (written only by the monitor)
    int strobes = 0, clrs = 0, dones = 0, viol = 0, rq_low = 0;
    logic chk_last = 1'b0;
    // per-run bases (written only by the stimulus process)
    int strobe_base = 0, clr_base = 0;

    // Z80 responder state and stimulus knobs
    int ack_on = 1, ack_lag = 3, lag_cnt = 0;
    int loss_at = -1, loss_len = 0, gap_left = 0;
    int loss_done = 0;
    int cen_mode = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (chk_last) begin
                if (busrq_n !== 1'b1) viol++;
                chk_last <= 1'b0;
            end
            if (dm_inc) begin
                strobes++;
                if (!cen || H != 2'b10 || busak_n || busrq_n || dm_clr || clrs == clr_base)
                    viol++;
                if (strobes - strobe_base == XFER_LEN) chk_last <= 1'b1;
            end
            if (dm_clr) begin
                clrs++;
                if (!cen) viol++;
            end
            if (dma_done) begin
                dones++;
                if (!cen) viol++;
            end
            if (dma_cs && (busak_n || H[1] || busrq_n)) viol++;
            if (gap_left > 0 && busrq_n) viol++;
            if (cen && !busrq_n) rq_low++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > 150000) begin
            $display("FAIL cycle_limit actual=%0d expected<=150000", cyc);
            $fatal(1, "cycle limit");
        end
        if (cen) begin
            H = H + 2'd1;
            if (gap_left > 0) begin
                busak_n = 1'b1;
                gap_left--;
                lag_cnt = 0;
            end else if (ack_on == 0) begin
                busak_n = 1'b1;
            end else if (loss_at >= 0 && loss_done == 0 && strobes - strobe_base == loss_at) begin
                busak_n  = 1'b1;
                gap_left = loss_len;
                loss_done = 1;
            end else if (busak_n != busrq_n) begin
                if (lag_cnt >= ack_lag) begin
                    busak_n = busrq_n;
                    lag_cnt = 0;
                end else begin
                    lag_cnt++;
                end
            end else begin
                lag_cnt = 0;
            end
        end
        case (cen_mode)
            1:       cen = (cyc % 3 == 0);
            2:       cen = 1'($urandom % 2);
            default: cen = 1'b1;
        endcase
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        steps(3);
        rst = 1'b0;
        step();
    endtask

    // Transaction-level expectation for one VB-triggered run.
    function automatic vec_t model(input int lag, input int mode, input int ack,
                                   input int la, input int ll);
        vec_t v;
        v.lag = lag; v.cen_mode = mode; v.ack_on = ack; v.loss_at = la; v.loss_len = ll;
        if (ack != 0) begin
            v.exp_strobes = XFER_LEN; v.exp_clr = 1; v.exp_done = 1;
            v.exp_tout = 0; v.exp_rqlow = -1;
        end else begin
            v.exp_strobes = 0; v.exp_clr = 0; v.exp_done = 0;
            v.exp_tout = 1; v.exp_rqlow = ACK_TIMEOUT;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm, input int en_drop);
        int s0, c0, d0, v0, r0, budget;
        ack_on = v.ack_on; ack_lag = v.lag; cen_mode = v.cen_mode;
        loss_at = v.loss_at; loss_len = v.loss_len; loss_done = 0; gap_left = 0;
        VB = 1'b0;
        steps(10);
        strobe_base = strobes; clr_base = clrs;
        s0 = strobes; c0 = clrs; d0 = dones; v0 = viol; r0 = rq_low;
        VB = 1'b1;
        steps(20);
        VB = 1'b0;
        budget = 20000;
        while (dma_busy && budget > 0) begin
            if (en_drop != 0 && strobes - s0 >= 10) dma_en = 1'b0;
            step();
            budget--;
        end
        dma_en = 1'b1;
        steps(10);
        check({nm, "_budget"}, int'(budget > 0), 1);
        check({nm, "_strobes"}, strobes - s0, v.exp_strobes);
        check({nm, "_clr"}, clrs - c0, v.exp_clr);
        check({nm, "_done"}, dones - d0, v.exp_done);
        check({nm, "_tout"}, int'(dma_tout), v.exp_tout);
        check({nm, "_viol"}, viol - v0, 0);
        check({nm, "_busrq_n"}, int'(busrq_n), 1);
        if (v.exp_rqlow >= 0) check({nm, "_rqlow"}, rq_low - r0, v.exp_rqlow);
    endtask

    task automatic vb_pulse_count(output int f1, output int f3);
        logic p1, p3;
        f1 = 0; f3 = 0;
        p1 = busrq_n; p3 = busrq3_n;
        VB = 1'b1;
        for (int i = 0; i < 310; i++) begin
            if (i == 10) VB = 1'b0;
            step();
            if (p1 && !busrq_n) f1++;
            if (p3 && !busrq3_n) f3++;
            p1 = busrq_n; p3 = busrq3_n;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int f1, f3, busy_seen, d0, budget;
        vec_t v;

        vecs[0] = '{3, 0, 1, -1, 0,  XFER_LEN, 1, 1, 0, -1};
        vecs[1] = '{0, 0, 0, -1, 0,  0,        0, 0, 1, ACK_TIMEOUT};
        vecs[2] = '{3, 2, 1, -1, 0,  XFER_LEN, 1, 1, 0, -1};
        vecs[3] = '{3, 0, 1, 100, 20, XFER_LEN, 1, 1, 0, -1};
        vecs[4] = '{3, 1, 1, -1, 0,  XFER_LEN, 1, 1, 0, -1};
        vecs[5] = '{0, 1, 0, -1, 0,  0,        0, 0, 1, ACK_TIMEOUT};

        apply_reset();
        check("rst_busrq_n", int'(busrq_n), 1);
        check("rst_busy", int'(dma_busy), 0);
        check("rst_tout", int'(dma_tout), 0);
        check("rst_dm_clr", int'(dm_clr), 0);
        check("rst_done", int'(dma_done), 0);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i), 0);

        for (int i = 0; i < 2; i++) begin
            int la, ll;
            la = ($urandom % 2 == 0) ? -1 : int'($urandom_range(1, 1000));
            ll = int'($urandom_range(1, 40));
            v = model(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                      int'($urandom % 4 != 0), la, ll);
            run_vec(v, $sformatf("rnd%0d", i), int'($urandom % 2));
        end

        // reset in the middle of a transfer, released while VB is still high
        ack_on = 1; ack_lag = 3; cen_mode = 0; loss_at = -1; gap_left = 0;
        VB = 1'b0;
        steps(10);
        strobe_base = strobes; clr_base = clrs;
        d0 = dones;
        VB = 1'b1;
        budget = 2000;
        while (strobes - strobe_base < 50 && budget > 0) begin
            step();
            budget--;
        end
        check("midrst_reach", int'(budget > 0), 1);
        rst = 1'b1;
        step();
        check("midrst_busrq_n", int'(busrq_n), 1);
        check("midrst_busy", int'(dma_busy), 0);
        rst = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dma_busy || !busrq_n) busy_seen++;
        end
        check("midrst_nostart", busy_seen, 0);
        check("midrst_nodone", dones - d0, 0);
        run_vec(vecs[0], "postrst", 0);

        // frame divider: dut runs every VB, dut3 on every third
        ack_on = 0; cen_mode = 0; VB = 1'b0;
        apply_reset();
        for (int p = 0; p < 5; p++) begin
            vb_pulse_count(f1, f3);
            check($sformatf("fdiv1_p%0d", p + 1), f1, 1);
            check($sformatf("fdiv3_p%0d", p + 1), f3, (p == 0 || p == 3) ? 1 : 0);
        end
        dma_en = 1'b0;
        for (int p = 0; p < 2; p++) begin
            vb_pulse_count(f1, f3);
            check($sformatf("en0_dut_p%0d", p + 6), f1, 0);
            check($sformatf("en0_dut3_p%0d", p + 6), f3, 0);
        end
        dma_en = 1'b1;
        vb_pulse_count(f1, f3);
        check("div_adv_dut_p8", f1, 1);
        check("div_adv_dut3_p8", f3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
